// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared constants, sample type, read-FSM states and the bit-reversal helper
// for the FFT output reorder stage.
package fft_bitrev_reorder_pkg;

  localparam int FLOAT_LEN = 32;
  localparam int CPLX_W    = 2 * FLOAT_LEN;
  localparam int POINT_LEN = 7;

  typedef logic [CPLX_W-1:0] sample_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Reverses the low 'width' bits of value; upper result bits stay zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] v;
    logic [31:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        r = {r[30:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_bram.sv
// Simple dual-port RAM holding both ping-pong halves; registered read,
// one cycle of latency, contents are never reset.
module bram_reorder_2n #(
  parameter int addr_w = 8,
  parameter int data_w = 64
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [addr_w-1:0] waddr_i,
  input  logic [data_w-1:0] wdata_i,
  input  logic [addr_w-1:0] raddr_i,
  output logic [data_w-1:0] rdata_o
);

  logic [data_w-1:0] mem_q [2**addr_w];
  logic [data_w-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Collects bit-reversed FFT frames into one half of a ping-pong buffer and
// replays each completed half in natural order as a gap-free burst.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int float_len = FLOAT_LEN,
  parameter int point_len = POINT_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*float_len-1:0] data_in,
  input  logic                   data_in_valid,
  output logic [2*float_len-1:0] data_out,
  output logic                   data_out_valid,
  output logic                   data_out_last
);

  localparam int W = 2 * float_len;
  localparam logic [point_len-1:0] CNT_MAX = {point_len{1'b1}};

  logic [point_len-1:0] wr_cnt_q;
  logic                 wr_bank_q;
  logic                 req_q;

  rd_state_e            state_q, state_d;
  logic [point_len-1:0] rd_cnt_q, rd_cnt_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 issue;
  logic [point_len-1:0] sel_cnt;
  logic                 sel_bank;
  logic [31:0]          sel_rev;
  logic [point_len:0]   raddr;

  logic                 v1_q, last1_q;
  logic [W-1:0]         ram_rdata;
  logic [W-1:0]         data_out_q;
  logic                 valid_q, last_q;

  logic                 wr_en;
  assign wr_en = data_in_valid && rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      req_q <= data_in_valid && (wr_cnt_q == CNT_MAX);
      if (data_in_valid) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (wr_cnt_q == CNT_MAX) begin
          wr_bank_q <= ~wr_bank_q;
        end
      end
    end
  end

  // The IDLE->READ transition issues address 0 in the same cycle so the
  // first sample reaches the output three cycles after the last input.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    issue     = 1'b0;
    sel_cnt   = rd_cnt_q;
    sel_bank  = rd_bank_q;
    case (state_q)
      RD_IDLE: begin
        if (req_q) begin
          issue     = 1'b1;
          sel_cnt   = '0;
          sel_bank  = ~wr_bank_q;
          rd_bank_d = ~wr_bank_q;
          rd_cnt_d  = point_len'(1);
          state_d   = RD_READ;
        end
      end
      RD_READ: begin
        issue    = 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == CNT_MAX) begin
          if (req_q) begin
            rd_bank_d = ~wr_bank_q;
          end else begin
            state_d = RD_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    sel_rev = bitrev(32'(sel_cnt), point_len);
    raddr   = {sel_bank, sel_rev[point_len-1:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RD_IDLE;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  bram_reorder_2n #(
    .addr_w (point_len + 1),
    .data_w (W)
  ) u_bram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i ({wr_bank_q, wr_cnt_q}),
    .wdata_i (data_in),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  // Flags travel two stages to line up with RAM data in the output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q       <= 1'b0;
      last1_q    <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      v1_q       <= issue;
      last1_q    <= issue && (sel_cnt == CNT_MAX);
      data_out_q <= v1_q ? ram_rdata : '0;
      valid_q    <= v1_q;
      last_q     <= last1_q;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = valid_q;
  assign data_out_last  = last_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomized bench: a frame-level model schedules every expected output by
// edge number and a negedge process compares the DUT against it each cycle.
module tb_fft_bitrev_reorder;
  import fft_bitrev_reorder_pkg::*;

  localparam int N = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic [63:0] data_out;
  logic        data_out_valid;
  logic        data_out_last;

  int compared   = 0;
  int mismatched = 0;
  int edge_n     = 0;

  logic [63:0] frame_q[$];
  logic [63:0] exp_d[int];
  bit          exp_l[int];

  bit          cap_en = 1'b0;
  int          cap_n  = 0;
  logic [63:0] cap[N];

  fft_bitrev_reorder #(.float_len(32), .point_len(7)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_last  (data_out_last)
  );

  always #5 clk = ~clk;

  function automatic int rev7(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < 7; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // Model: a frame accepted completely at edge e shows output k after edge e+2+k.
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (!rst) begin
      frame_q.delete();
      for (int m = edge_n; m < edge_n + 4 * N; m++) begin
        if (exp_d.exists(m)) begin
          exp_d.delete(m);
          exp_l.delete(m);
        end
      end
    end else if (data_in_valid) begin
      frame_q.push_back(data_in);
      if (frame_q.size() == N) begin
        for (int k = 0; k < N; k++) begin
          exp_d[edge_n + 2 + k] = frame_q[rev7(k)];
          exp_l[edge_n + 2 + k] = (k == N - 1);
        end
        frame_q.delete();
      end
    end
  end

  always @(negedge clk) begin
    logic        ev;
    logic [63:0] ed;
    logic        el;
    if (edge_n > 0) begin
      if (exp_d.exists(edge_n)) begin
        ev = 1'b1; ed = exp_d[edge_n]; el = exp_l[edge_n];
      end else begin
        ev = 1'b0; ed = '0; el = 1'b0;
      end
      compared++;
      if (data_out_valid !== ev || data_out !== ed || data_out_last !== el) begin
        mismatched++;
        $display("FAIL cycle_check edge=%0d got v=%b d=%h l=%b want v=%b d=%h l=%b",
                 edge_n, data_out_valid, data_out, data_out_last, ev, ed, el);
      end
      if (cap_en && data_out_valid && cap_n < N) begin
        cap[cap_n] = data_out;
        cap_n++;
      end
    end
  end

  task automatic drive(input logic v, input logic [63:0] d);
    data_in_valid = v;
    data_in       = d;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    data_in       = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 64'h0);
  endtask

  // mode 0: {p,~p}; mode 1: random data. gap_max: random idle cycles after each sample.
  task automatic send_frame(input int mode, input int gap_min, input int gap_max, input int count);
    logic [63:0] d;
    for (int p = 0; p < count; p++) begin
      if (mode == 0) d = {32'(p), ~32'(p)};
      else           d = {$urandom, $urandom};
      drive(1'b1, d);
      idle($urandom_range(gap_max, gap_min));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
  endtask

  task automatic pin(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // natural-order frame, continuous valid, captured for literal pins
    cap_n  = 0;
    cap_en = 1'b1;
    send_frame(0, 0, 0, N);
    idle(140);
    cap_en = 1'b0;
    pin("burst_len", 64'(cap_n), 64'd128);
    pin("out0",   cap[0],   64'h00000000_FFFFFFFF);
    pin("out1",   cap[1],   64'h00000040_FFFFFFBF);
    pin("out2",   cap[2],   64'h00000020_FFFFFFDF);
    pin("out127", cap[127], 64'h0000007F_FFFFFF80);

    // same frame, valid every third cycle
    send_frame(0, 2, 2, N);
    idle(140);

    // four back-to-back random frames at full rate
    send_frame(1, 0, 0, 4 * N);
    idle(140);

    // random gaps inside a frame
    send_frame(1, 0, 3, N);
    idle(140);

    // reset after 50 samples, then a fresh frame
    send_frame(1, 0, 0, 50);
    do_reset();
    send_frame(1, 0, 0, N);
    idle(140);

    // reset in the middle of an output burst, then a normal frame
    send_frame(1, 0, 0, N);
    idle(60);
    do_reset();
    send_frame(1, 0, 1, N);
    idle(140);

    // idle after reset
    do_reset();
    idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
